// File: rtl/warp_pkg.sv
// rtl/warp_pkg.sv - shared defaults and helpers for the warp scheduler slice
package warp_pkg;

    localparam int DEFAULT_NUM_WARPS = 4;
    localparam int DEFAULT_PC_WIDTH  = 8;

    // Warp id width; a single warp still needs one bit to carry an id.
    function automatic int wid_width(input int num_warps);
        return (num_warps <= 1) ? 1 : $clog2(num_warps);
    endfunction

    // LSB of warp idx's PC inside the flattened warp_pc bus.
    function automatic int pc_lsb(input int idx, input int pc_width);
        return idx * pc_width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with start pointer
//   req   : request vector
//   start : first index to consider; search wraps at N-1 -> 0
//   grant : one-hot grant (all-zero when nothing is requested)
//   idx   : encoded grant index
//   any   : at least one request present
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int s;
        int p;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        s     = int'(start);
        // A start beyond the last warp can only come from a non-power-of-two
        // pointer width; treat it as zero rather than searching off the end.
        if (s >= N) s = 0;
        p = 0;
        for (int k = 0; k < N; k++) begin
            p = s + k;
            if (p >= N) p = p - N;
            if (!any && req[p]) begin
                any      = 1'b1;
                grant[p] = 1'b1;
                idx      = W'(p);
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - round-robin warp issue with per-warp issue gap
//   clk, reset_n  : clock, asynchronous active-low reset
//   sched_en      : global enable for new grants (slot still drains)
//   warp_ready    : per-warp readiness
//   warp_pc       : flattened per-warp PCs, warp i at [i*PC_WIDTH +: PC_WIDTH]
//   pc_update_en  : one-hot grant pulse to the warp-state blocks
//   issue_valid / issue_ready / issue_warp_id / issue_pc : issue slot to fetch
module warp_scheduler
    import warp_pkg::*;
#(
    parameter int NUM_WARPS = DEFAULT_NUM_WARPS,
    parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter int ISSUE_GAP = 2,
    parameter int WID_WIDTH = wid_width(NUM_WARPS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sched_en,
    input  logic [NUM_WARPS-1:0]          warp_ready,
    input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
    output logic [NUM_WARPS-1:0]          pc_update_en,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [WID_WIDTH-1:0]          issue_warp_id,
    output logic [PC_WIDTH-1:0]           issue_pc
);

    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(ISSUE_GAP);
    localparam logic [WID_WIDTH-1:0] LAST_WID = WID_WIDTH'(NUM_WARPS - 1);

    logic [WID_WIDTH-1:0] rr_ptr;
    logic [GAP_W-1:0]     gap_cnt [NUM_WARPS];
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] arb_grant;
    logic [WID_WIDTH-1:0] arb_idx;
    logic                 arb_any;
    logic                 load;
    logic                 do_grant;
    logic [PC_WIDTH-1:0]  grant_pc;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            eligible[i] = warp_ready[i] && (gap_cnt[i] == '0);
        end
    end

    rr_arbiter #(
        .N (NUM_WARPS),
        .W (WID_WIDTH)
    ) u_arb (
        .req   (eligible),
        .start (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // The slot can take a new entry when empty or when fetch is taking the
    // current one this cycle, which gives one issue per cycle at full rate.
    assign load     = sched_en && (!issue_valid || issue_ready);
    assign do_grant = load && arb_any;

    // Gated by reset_n so the warp-state blocks never see a pulse during reset.
    assign pc_update_en = (do_grant && reset_n) ? arb_grant : '0;

    always_comb begin
        grant_pc = warp_pc[pc_lsb(int'(arb_idx), PC_WIDTH) +: PC_WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid   <= 1'b0;
            issue_warp_id <= '0;
            issue_pc      <= '0;
            rr_ptr        <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                gap_cnt[i] <= '0;
            end
        end else begin
            if (do_grant) begin
                issue_valid   <= 1'b1;
                issue_warp_id <= arb_idx;
                issue_pc      <= grant_pc;
                rr_ptr        <= (arb_idx == LAST_WID) ? '0 : arb_idx + WID_WIDTH'(1);
            end else if (issue_valid && issue_ready) begin
                issue_valid <= 1'b0;
            end

            // Counters run regardless of backpressure so a stalled warp's gap
            // keeps elapsing while the slot is held.
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (do_grant && arb_grant[i]) begin
                    gap_cnt[i] <= GAP_LOAD;
                end else if (gap_cnt[i] != '0) begin
                    gap_cnt[i] <= gap_cnt[i] - GAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - self-checking bench for warp_scheduler
module tb_warp_scheduler;

    localparam int NW  = 4;
    localparam int PW  = 8;
    localparam int GAP = 2;
    localparam int WW  = 2;

    logic             clk;
    logic             reset_n;
    logic             sched_en;
    logic [NW-1:0]    warp_ready;
    logic [NW*PW-1:0] warp_pc;
    logic [NW-1:0]    pc_update_en;
    logic             issue_valid;
    logic             issue_ready;
    logic [WW-1:0]    issue_warp_id;
    logic [PW-1:0]    issue_pc;

    int n_checks = 0;
    int n_fails  = 0;

    warp_scheduler #(
        .NUM_WARPS (NW),
        .PC_WIDTH  (PW),
        .ISSUE_GAP (GAP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sched_en      (sched_en),
        .warp_ready    (warp_ready),
        .warp_pc       (warp_pc),
        .pc_update_en  (pc_update_en),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_warp_id (issue_warp_id),
        .issue_pc      (issue_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated at the falling edge with inputs stable.
    int          m_rr;
    int          m_gap [NW];
    logic        m_valid;
    logic [15:0] sb_q [$];

    always @(negedge clk) begin
        int   g;
        logic m_load;
        logic [NW-1:0] exp_pue;
        g = -1;
        exp_pue = '0;
        m_load = 1'b0;
        if (!reset_n) begin
            m_rr    = 0;
            m_valid = 1'b0;
            for (int i = 0; i < NW; i++) m_gap[i] = 0;
            sb_q.delete();
            check("rst_pue", 32'(pc_update_en), 32'h0);
        end else begin
            m_load = sched_en && (!m_valid || issue_ready);
            if (m_load) begin
                for (int k = 0; k < NW; k++) begin
                    int i;
                    i = (m_rr + k) % NW;
                    if (g < 0 && warp_ready[i] && m_gap[i] == 0) g = i;
                end
            end
            if (g >= 0) exp_pue[g] = 1'b1;
            check("pue", 32'(pc_update_en), 32'(exp_pue));
            check("valid", 32'(issue_valid), 32'(m_valid));
            if (m_valid) begin
                check("sb_size", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    check("slot_id", 32'(issue_warp_id), 32'(sb_q[0][15:8]));
                    check("slot_pc", 32'(issue_pc), 32'(sb_q[0][7:0]));
                    if (issue_ready) void'(sb_q.pop_front());
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (g == i) m_gap[i] = GAP;
                else if (m_gap[i] > 0) m_gap[i] = m_gap[i] - 1;
            end
            if (g >= 0) begin
                sb_q.push_back({8'(g), warp_pc[g*PW +: PW]});
                m_valid = 1'b1;
                m_rr    = (g == NW - 1) ? 0 : g + 1;
            end else if (m_valid && issue_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        warp_ready = '0;
        issue_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        sched_en    = 1'b1;
        warp_ready  = 4'hF;
        issue_ready = 1'b1;
        warp_pc     = {8'h60, 8'h40, 8'h20, 8'h10};

        // Reset held three cycles with all warps ready.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_valid", 32'(issue_valid), 32'h0);
            check("rst_id", 32'(issue_warp_id), 32'h0);
            check("rst_pc", 32'(issue_pc), 32'h0);
            check("rst_pue_d", 32'(pc_update_en), 32'h0);
        end
        tick();
        reset_n = 1'b1;

        // Round robin from warp 0.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'b0001 << (k % 4);
            @(negedge clk);
            check("rr_seq", 32'(pc_update_en), 32'(e));
            tick();
        end

        // Issue gap: only warp 1 ready.
        idle(4);
        warp_ready = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("gap_pue", 32'(pc_update_en), (c % 3 == 0) ? 32'h2 : 32'h0);
            tick();
        end

        // Backpressure: warp 2 granted, slot held for four cycles.
        idle(4);
        warp_ready = 4'b1100;
        @(negedge clk);
        check("bp_grant", 32'(pc_update_en), 32'h4);
        tick();
        issue_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_pue", 32'(pc_update_en), 32'h0);
            check("bp_valid", 32'(issue_valid), 32'h1);
            check("bp_id", 32'(issue_warp_id), 32'h2);
            check("bp_pc", 32'(issue_pc), 32'h40);
            tick();
        end
        issue_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_grant", 32'(pc_update_en), 32'h8);
        tick();
        @(negedge clk);
        check("bp_next_id", 32'(issue_warp_id), 32'h3);
        check("bp_next_pc", 32'(issue_pc), 32'h60);

        // Wrap / skip: leave rr_ptr at 3, then ready = 0101.
        tick();
        idle(4);
        warp_ready = 4'b0100;
        tick();
        idle(3);
        warp_ready = 4'b0101;
        @(negedge clk);
        check("wrap_first", 32'(pc_update_en), 32'h1);
        tick();
        @(negedge clk);
        check("wrap_second", 32'(pc_update_en), 32'h4);
        tick();

        // Enable off: held entry, no grants, drain on accept.
        sched_en    = 1'b0;
        warp_ready  = 4'hF;
        issue_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("en_pue", 32'(pc_update_en), 32'h0);
            check("en_valid", 32'(issue_valid), 32'h1);
            tick();
        end
        issue_ready = 1'b1;
        @(negedge clk);
        check("en_drain_pue", 32'(pc_update_en), 32'h0);
        tick();
        @(negedge clk);
        check("en_drained", 32'(issue_valid), 32'h0);
        check("en_idle_pue", 32'(pc_update_en), 32'h0);

        // Idle: single grant, then nothing ready, slot drops after accept.
        tick();
        sched_en   = 1'b1;
        warp_ready = 4'b0001;
        tick();
        warp_ready = '0;
        @(negedge clk);
        check("idle_valid", 32'(issue_valid), 32'h1);
        tick();
        @(negedge clk);
        check("idle_dropped", 32'(issue_valid), 32'h0);

        // Mid-handshake reset.
        tick();
        warp_ready  = 4'hF;
        issue_ready = 1'b0;
        tick();
        @(negedge clk);
        check("mh_valid", 32'(issue_valid), 32'h1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mh_async_valid", 32'(issue_valid), 32'h0);
        check("mh_async_pue", 32'(pc_update_en), 32'h0);
        repeat (2) @(negedge clk);
        tick();
        reset_n     = 1'b1;
        issue_ready = 1'b1;
        @(negedge clk);
        check("mh_first_grant", 32'(pc_update_en), 32'h1);
        tick();
        idle(4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
